// File: rtl/mult_pkg.sv
// Shared definitions for the lab3 multiplier datapath (seq_multiplier, shift_out).
package mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int N      = 12;
    localparam int PROD_W = 2 * N;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : mult_pkg

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add M into the accumulator, then
// shift the {A,Q} pair right by one with a zero entering the MSB.
module mul_step #(
    parameter int N = 12
) (
    input  logic [N:0]   a_i,
    input  logic [N-1:0] q_i,
    input  logic [N-1:0] m_i,
    output logic [N:0]   a_o,
    output logic [N-1:0] q_o
);

    logic [N:0] sum_s;

    // Conditional add of the multiplicand; the carry lands in the extra A bit.
    always_comb begin
        if (q_i[0]) begin
            sum_s = a_i + {1'b0, m_i};
        end else begin
            sum_s = a_i;
        end
    end

    // Right shift of {sum,Q}: the LSB of the sum moves into the top of Q.
    always_comb begin
        a_o = {1'b0, sum_s[N:1]};
        q_o = {sum_s[0], q_i[N-1:1]};
    end

endmodule : mul_step

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier feeding shift_out. Captures two
// operands on start, runs N add/shift steps, then holds the product with sz=1.
module seq_multiplier #(
    parameter int N = mult_pkg::N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   x_parallel,
    input  logic [N-1:0]   y_parallel,
    output logic [2*N-1:0] z_parallel,
    output logic           sz,
    output logic           busy
);

    import mult_pkg::*;

    localparam int CNT_W = $clog2(N);

    state_t         state_q, state_d;
    logic [N:0]     a_q, a_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0] z_q, z_d;
    logic           sz_q, sz_d;
    logic           busy_q, busy_d;

    logic [N:0]     step_a_s;
    logic [N-1:0]   step_q_s;

    mul_step #(.N(N)) u_mul_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a_s),
        .q_o (step_q_s)
    );

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            sz_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            sz_q    <= sz_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; start is only honoured outside CALC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = CALC;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: operand capture on an accepted start, one step per CALC cycle.
    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        m_d   = m_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d   = '0;
                    q_d   = y_parallel;
                    m_d   = x_parallel;
                    cnt_d = '0;
                end else begin
                    a_d   = a_q;
                    q_d   = q_q;
                    m_d   = m_q;
                    cnt_d = cnt_q;
                end
            end
            CALC: begin
                a_d   = step_a_s;
                q_d   = step_q_s;
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
                a_d   = '0;
                q_d   = '0;
                m_d   = '0;
                cnt_d = '0;
            end
        endcase
    end

    // Output next values derived from the next state so the ports are registered.
    always_comb begin
        if (state_d == DONE) begin
            z_d    = {a_d[N-1:0], q_d};
            sz_d   = 1'b1;
            busy_d = 1'b0;
        end else if (state_d == CALC) begin
            z_d    = '0;
            sz_d   = 1'b0;
            busy_d = 1'b1;
        end else begin
            z_d    = '0;
            sz_d   = 1'b0;
            busy_d = 1'b0;
        end
    end

    assign z_parallel = z_q;
    assign sz         = sz_q;
    assign busy       = busy_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier.
module tb_seq_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] x_parallel;
    logic [11:0] y_parallel;
    logic [23:0] z_parallel;
    logic        sz;
    logic        busy;

    int n_checks;
    int n_fail;

    seq_multiplier #(.N(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x_parallel (x_parallel),
        .y_parallel (y_parallel),
        .z_parallel (z_parallel),
        .sz         (sz),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_sz"},   32'(sz),         32'd0);
        check_val({tag, "_busy"}, 32'(busy),       32'd0);
        check_val({tag, "_z"},    32'(z_parallel), 32'd0);
    endtask

    // Called right after edge 0; walks edges 1..12 and checks the result.
    // ign_cycle >= 1 pulses start with full-scale operands during that CALC cycle.
    task automatic finish_calc(input string tag, input logic [23:0] exp_z, input int ign_cycle);
        for (int i = 1; i <= 11; i++) begin
            tick();
            check_val({tag, "_busy"}, 32'(busy), 32'd1);
            check_val({tag, "_sz"},   32'(sz),   32'd0);
            if (i == ign_cycle) begin
                start      = 1'b1;
                x_parallel = 12'hFFF;
                y_parallel = 12'hFFF;
            end else begin
                start      = 1'b0;
            end
        end
        tick();
        check_val({tag, "_done_sz"},   32'(sz),         32'd1);
        check_val({tag, "_done_busy"}, 32'(busy),       32'd0);
        check_val({tag, "_done_z"},    32'(z_parallel), 32'(exp_z));
    endtask

    task automatic run_mult(input string tag, input logic [11:0] x, input logic [11:0] y,
                            input logic [23:0] exp_z, input int ign_cycle);
        start      = 1'b1;
        x_parallel = x;
        y_parallel = y;
        tick();
        start      = 1'b0;
        x_parallel = 12'h5A5;
        y_parallel = 12'hA5A;
        check_val({tag, "_e0_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_e0_sz"},   32'(sz),   32'd0);
        finish_calc(tag, exp_z, ign_cycle);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        start      = 1'b1;
        x_parallel = 12'd3;
        y_parallel = 12'd5;

        // Reset dominates a held start.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("rst_hold");
        end
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_idle("post_rst_idle");
        end

        run_mult("m3x5", 12'd3, 12'd5, 24'h00000F, -1);
        run_mult("mFFFxFFF", 12'hFFF, 12'hFFF, 24'hFFE001, -1);
        run_mult("m0xFFF", 12'h000, 12'hFFF, 24'h000000, -1);
        run_mult("m800x2_ign", 12'h800, 12'h002, 24'h001000, 5);

        // Result held through DONE.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("done_hold_sz", 32'(sz), 32'd1);
            check_val("done_hold_z",  32'(z_parallel), 32'h001000);
        end

        // Restart from DONE: sz must drop right after the accepted start.
        run_mult("m7x9", 12'd7, 12'd9, 24'h00003F, -1);
        run_mult("m123x010", 12'h123, 12'h010, 24'h001230, -1);

        // Start held high: back-to-back multiplies with a one-cycle sz pulse.
        start      = 1'b1;
        x_parallel = 12'd2;
        y_parallel = 12'd3;
        tick();
        check_val("held_e0_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            tick();
        end
        check_val("held_done_sz", 32'(sz), 32'd1);
        check_val("held_done_z",  32'(z_parallel), 32'h000006);
        tick();
        check_val("held_pulse_sz",   32'(sz),   32'd0);
        check_val("held_pulse_busy", 32'(busy), 32'd1);
        start = 1'b0;
        finish_calc("held2", 24'h000006, -1);

        // Reset in the middle of CALC aborts without exposing a partial product.
        start      = 1'b1;
        x_parallel = 12'hFFF;
        y_parallel = 12'hFFF;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
        end
        check_val("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        check_idle("abort");
        reset = 1'b1;
        tick();
        check_idle("abort_idle");

        run_mult("mABCx1", 12'hABC, 12'h001, 24'h000ABC, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule : tb_seq_multiplier
